// File: rtl/pixel_serializer_pkg.sv
// Shared constants and types for the character-row pixel serializer.
// Holds the colour/row widths, the black index and the pixel-count range.
package pixel_serializer_pkg;

  localparam int COLOR_W = 3;
  localparam int ROW_W   = 8;
  localparam int COUNT_W = 3;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [COUNT_W-1:0] count_t;

  localparam color_t BLACK     = 3'b000;
  localparam count_t COUNT_MIN = 3'd0;
  localparam count_t COUNT_MAX = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } shift_state_t;

  // Pixels leave MSB first: count 0 selects bit 7, the leftmost pixel.
  function automatic logic row_bit(input row_t row, input count_t count);
    return row[COUNT_MAX - count];
  endfunction

endpackage

// File: rtl/pixel_serializer_if.sv
// Load channel, pixel strobe and pixel output bundle of the serializer.
// master = row source / pixel consumer, slave = serializer.
interface pixel_serializer_if;
  import pixel_serializer_pkg::*;

  logic   pixel_enable;
  logic   load_valid;
  logic   load_ready;
  row_t   row_pixels;
  color_t fg_color;
  color_t bg_color;
  logic   blink;
  logic   blink_phase;
  color_t pixel_color;
  logic   pixel_active;
  logic   underrun;

  modport master (
    output pixel_enable, load_valid, row_pixels, fg_color, bg_color, blink, blink_phase,
    input  load_ready, pixel_color, pixel_active, underrun
  );

  modport slave (
    input  pixel_enable, load_valid, row_pixels, fg_color, bg_color, blink, blink_phase,
    output load_ready, pixel_color, pixel_active, underrun
  );

endinterface

// File: rtl/pixel_serializer.sv
// Two-stage (holding + shift) character-row to pixel serializer.
// Optional blink attribute enabled by defining SERIALIZER_BLINK_EN.
module pixel_serializer
  import pixel_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  pixel_serializer_if.slave bus
);

  shift_state_t state_reg, state_next;
  count_t       count_reg, count_next;
  row_t         shift_row_reg, shift_row_next;
  color_t       shift_fg_reg, shift_fg_next;
  color_t       shift_bg_reg, shift_bg_next;
  row_t         hold_row_reg, hold_row_next;
  color_t       hold_fg_reg, hold_fg_next;
  color_t       hold_bg_reg, hold_bg_next;
  logic         hold_full_reg, hold_full_next;
  color_t       color_reg, color_next;
  logic         active_reg, active_next;
  logic         underrun_reg, underrun_next;
  logic         load_accept;
  logic         take_hold;
  logic         pixel_bit;
  logic         show_fg;

  assign load_accept = bus.load_valid & ~hold_full_reg;
  assign pixel_bit   = row_bit(shift_row_reg, count_reg);

`ifdef SERIALIZER_BLINK_EN
  logic shift_blink_reg, shift_blink_next;
  logic hold_blink_reg, hold_blink_next;

  // blink_phase is sampled live so every blinking row toggles together.
  assign show_fg = pixel_bit & ~(shift_blink_reg & bus.blink_phase);

  always_comb begin
    hold_blink_next  = hold_blink_reg;
    shift_blink_next = shift_blink_reg;
    if (load_accept) hold_blink_next = bus.blink;
    if (take_hold)   shift_blink_next = hold_blink_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_blink_reg  <= 1'b0;
      shift_blink_reg <= 1'b0;
    end else begin
      hold_blink_reg  <= hold_blink_next;
      shift_blink_reg <= shift_blink_next;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = bus.blink ^ bus.blink_phase;
  assign show_fg      = pixel_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_EMPTY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    shift_row_next = shift_row_reg;
    shift_fg_next  = shift_fg_reg;
    shift_bg_next  = shift_bg_reg;
    hold_row_next  = hold_row_reg;
    hold_fg_next   = hold_fg_reg;
    hold_bg_next   = hold_bg_reg;
    hold_full_next = hold_full_reg;
    color_next     = color_reg;
    active_next    = active_reg;
    underrun_next  = 1'b0;
    take_hold      = 1'b0;

    if (load_accept) begin
      hold_row_next  = bus.row_pixels;
      hold_fg_next   = bus.fg_color;
      hold_bg_next   = bus.bg_color;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      ST_EMPTY: begin
        if (bus.pixel_enable) begin
          color_next    = BLACK;
          active_next   = 1'b0;
          underrun_next = 1'b1;
        end
        take_hold = hold_full_reg;
      end
      ST_RUN: begin
        if (bus.pixel_enable) begin
          color_next  = show_fg ? shift_fg_reg : shift_bg_reg;
          active_next = 1'b1;
          if (count_reg == COUNT_MAX) begin
            // Last pixel: chain straight into the held row if one is waiting.
            take_hold = hold_full_reg;
            if (!hold_full_reg) begin
              state_next = ST_EMPTY;
              count_next = COUNT_MIN;
            end
          end else begin
            count_next = count_reg + 3'd1;
          end
        end
      end
      default: state_next = ST_EMPTY;
    endcase

    if (take_hold) begin
      shift_row_next = hold_row_reg;
      shift_fg_next  = hold_fg_reg;
      shift_bg_next  = hold_bg_reg;
      count_next     = COUNT_MIN;
      state_next     = ST_RUN;
      hold_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg     <= COUNT_MIN;
      shift_row_reg <= '0;
      shift_fg_reg  <= BLACK;
      shift_bg_reg  <= BLACK;
      hold_row_reg  <= '0;
      hold_fg_reg   <= BLACK;
      hold_bg_reg   <= BLACK;
      hold_full_reg <= 1'b0;
      color_reg     <= BLACK;
      active_reg    <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      count_reg     <= count_next;
      shift_row_reg <= shift_row_next;
      shift_fg_reg  <= shift_fg_next;
      shift_bg_reg  <= shift_bg_next;
      hold_row_reg  <= hold_row_next;
      hold_fg_reg   <= hold_fg_next;
      hold_bg_reg   <= hold_bg_next;
      hold_full_reg <= hold_full_next;
      color_reg     <= color_next;
      active_reg    <= active_next;
      underrun_reg  <= underrun_next;
    end
  end

  assign bus.load_ready   = ~hold_full_reg;
  assign bus.pixel_color  = color_reg;
  assign bus.pixel_active = active_reg;
  assign bus.underrun     = underrun_reg;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed self-checking bench for pixel_serializer (both blink builds).
// Covers reset, underrun, single row, back-to-back, stall, reset mid-row, blink.
module tb_pixel_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pixel_serializer_if bus ();

  pixel_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] exp_single [8] = '{3'd7, 3'd1, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
  logic [2:0] exp_stall  [8] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};
  logic [2:0] exp_blink0 [8] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
`ifdef SERIALIZER_BLINK_EN
  logic [2:0] exp_blink1 [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
  logic [2:0] exp_blink1 [8] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_pixel(input string tag, input logic [2:0] color,
                             input logic active, input logic under);
    check({tag, "_color"}, {5'd0, bus.pixel_color}, {5'd0, color});
    check({tag, "_active"}, {7'd0, bus.pixel_active}, {7'd0, active});
    check({tag, "_underrun"}, {7'd0, bus.underrun}, {7'd0, under});
  endtask

  // One enabled pixel cycle, then the registered outputs are compared.
  task automatic pixel(input string tag, input logic [2:0] color,
                       input logic active, input logic under);
    bus.pixel_enable = 1'b1;
    step();
    bus.pixel_enable = 1'b0;
    check_pixel(tag, color, active, under);
  endtask

  task automatic drive_row(input logic [7:0] row, input logic [2:0] fg,
                           input logic [2:0] bg, input logic bl);
    bus.row_pixels = row;
    bus.fg_color   = fg;
    bus.bg_color   = bg;
    bus.blink      = bl;
    bus.load_valid = 1'b1;
    $display("load row=%h fg=%0d bg=%0d blink=%0b", row, fg, bg, bl);
  endtask

  // Accept a row into an empty pipeline and let it move into the shifter.
  task automatic prime_row(input string tag, input logic [7:0] row, input logic [2:0] fg,
                           input logic [2:0] bg, input logic bl);
    drive_row(row, fg, bg, bl);
    step();
    bus.load_valid = 1'b0;
    check({tag, "_hold_full"}, {7'd0, bus.load_ready}, 8'd0);
    step();
    check({tag, "_ready_again"}, {7'd0, bus.load_ready}, 8'd1);
  endtask

  initial begin
    bus.pixel_enable = 1'b0;
    bus.load_valid   = 1'b0;
    bus.row_pixels   = '0;
    bus.fg_color     = '0;
    bus.bg_color     = '0;
    bus.blink        = 1'b0;
    bus.blink_phase  = 1'b0;

    step();
    step();
    check_pixel("reset", 3'd0, 1'b0, 1'b0);
    check("reset_ready", {7'd0, bus.load_ready}, 8'd1);
    reset = 1'b0;
    step();

    // Underrun with nothing loaded
    pixel("under1", 3'd0, 1'b0, 1'b1);
    pixel("under2", 3'd0, 1'b0, 1'b1);
    step();
    check_pixel("under_idle", 3'd0, 1'b0, 1'b0);

    // Single row
    prime_row("single", 8'b1010_0000, 3'd7, 3'd1, 1'b0);
    for (int i = 0; i < 8; i++) pixel($sformatf("single_px%0d", i), exp_single[i], 1'b1, 1'b0);
    pixel("single_end", 3'd0, 1'b0, 1'b1);

    // Back-to-back rows: second row is accepted during the first pixel
    prime_row("b2b", 8'hFF, 3'd2, 3'd5, 1'b0);
    drive_row(8'h00, 3'd2, 3'd5, 1'b0);
    pixel("b2b_px0", 3'd2, 1'b1, 1'b0);
    bus.load_valid = 1'b0;
    check("b2b_held", {7'd0, bus.load_ready}, 8'd0);
    for (int i = 1; i < 16; i++)
      pixel($sformatf("b2b_px%0d", i), (i < 8) ? 3'd2 : 3'd5, 1'b1, 1'b0);
    pixel("b2b_end", 3'd0, 1'b0, 1'b1);

    // Stall: enable every other cycle
    prime_row("stall", 8'h81, 3'd3, 3'd4, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pixel($sformatf("stall_px%0d", i), exp_stall[i], 1'b1, 1'b0);
      step();
      check_pixel($sformatf("stall_idle%0d", i), exp_stall[i], 1'b1, 1'b0);
    end
    pixel("stall_end", 3'd0, 1'b0, 1'b1);

    // Reset after 3 pixels with a second row in the holding stage
    prime_row("rst", 8'hAA, 3'd1, 3'd2, 1'b0);
    drive_row(8'h55, 3'd6, 3'd3, 1'b0);
    pixel("rst_px0", 3'd1, 1'b1, 1'b0);
    bus.load_valid = 1'b0;
    pixel("rst_px1", 3'd2, 1'b1, 1'b0);
    pixel("rst_px2", 3'd1, 1'b1, 1'b0);
    check("rst_hold_full", {7'd0, bus.load_ready}, 8'd0);
    #2 reset = 1'b1;
    #1;
    check_pixel("rst_async", 3'd0, 1'b0, 1'b0);
    check("rst_ready", {7'd0, bus.load_ready}, 8'd1);
    step();
    reset = 1'b0;
    pixel("rst_under1", 3'd0, 1'b0, 1'b1);
    pixel("rst_under2", 3'd0, 1'b0, 1'b1);

    // Blink attribute, phase 1 then phase 0
    prime_row("blink1", 8'hF0, 3'd6, 3'd0, 1'b1);
    bus.blink_phase = 1'b1;
    for (int i = 0; i < 8; i++) pixel($sformatf("blink1_px%0d", i), exp_blink1[i], 1'b1, 1'b0);
    prime_row("blink0", 8'hF0, 3'd6, 3'd0, 1'b1);
    bus.blink_phase = 1'b0;
    for (int i = 0; i < 8; i++) pixel($sformatf("blink0_px%0d", i), exp_blink0[i], 1'b1, 1'b0);
    pixel("blink_end", 3'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 clk  input  1  pixel-domain clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 pixel_enable  input  1  advance one pixel position this cycle.
REQ-004 load_valid  input  1  row_pixels, fg_color and bg_color carry a new character row.
REQ-005 load_ready  output  1  holding buffer empty; row accepted when load_valid & load_ready.
REQ-006 row_pixels  input  8  character row; bit 7 is the leftmost pixel.
REQ-007 fg_color  input  3  foreground colour index for the loaded row.
REQ-008 bg_color  input  3  background colour index for the loaded row.
REQ-009 blink  input  1  blink attribute for the loaded row.
REQ-010 blink_phase  input  1  global blink phase, sampled live (not latched with the row).
REQ-011 pixel_color  output  3  registered colour of the current pixel.
REQ-012 pixel_active  output  1  registered; pixel_color came from valid row data.
REQ-013 underrun  output  1  registered one-cycle pulse: pixel_enable while shifter empty.

Function
REQ-014 Two-stage buffer SHALL be used: holding register (row, fg, bg, blink, hold_full) plus shift register (row, fg, bg, blink, 3-bit count, state).
REQ-015 Shifter state machine SHALL have states EMPTY and RUN.
REQ-016 load_ready SHALL equal ~hold_full, registered with no combinational path from load_valid.
REQ-017 An accepted load SHALL set hold_full at the next edge.
REQ-018 In EMPTY with hold_full, the holding contents SHALL move to the shifter at the next edge: count=0, state RUN, hold_full cleared.
REQ-019 A row accepted while both stages are empty SHALL reach the shifter one cycle after acceptance.
REQ-020 In RUN with pixel_enable, pixel_color SHALL update at the next edge to fg when row[7-count]=1, else bg.
REQ-021 In RUN with pixel_enable, pixel_active SHALL be 1 at the next edge, and count SHALL increment.
REQ-022 In RUN, pixel_enable with count=7 and hold_full SHALL reload the shifter from the holding register on the same edge (count=0, hold_full cleared), giving a gapless stream.
REQ-023 In RUN, pixel_enable with count=7 and no hold_full SHALL move the state to EMPTY.
REQ-024 A load accepted on the same edge as a reload SHALL NOT occur, since load_ready=0 whenever hold_full=1.
REQ-025 In EMPTY, pixel_enable SHALL give pixel_color=000, pixel_active=0 and underrun=1 at the next edge.
REQ-026 Without pixel_enable, pixel_color, pixel_active and count SHALL hold and underrun SHALL be 0.
REQ-027 A completed 8-pixel row SHALL take exactly 8 pixel_enable cycles; cycles without pixel_enable are stall cycles.

Reset
REQ-028 On reset: state=EMPTY, count=0, hold_full=0, load_ready=1, pixel_color=000, pixel_active=0, underrun=0.
REQ-029 Reset asserted mid-row SHALL discard both stages immediately; no pixel of the discarded rows SHALL appear after release.

Configuration
REQ-030 Macro SERIALIZER_BLINK_EN defined: when the shifter's blink=1 and blink_phase=1, foreground pixels SHALL be output as bg.
REQ-031 Macro SERIALIZER_BLINK_EN undefined: blink and blink_phase SHALL be ignored, with no blink storage in either stage.

Structure
REQ-032 The shared constant header SHALL hold the colour width (3), row width (8), black index (000) and pixel-count range.
REQ-033 No sub-module is needed; a single module with one holding and one shift stage is sufficient.

Verification
REQ-034 Single row: load row=8'b1010_0000, fg=7, bg=1, then 8 continuous pixel_enable -> pixel_color 7,1,7,1,1,1,1,1 and pixel_active=1 for all 8.
REQ-035 Back-to-back: load rows 8'hFF then 8'h00 (fg=2, bg=5) while streaming -> 8 pixels of 2 then 8 of 5, with no gap and underrun never 1.
REQ-036 Stall: pixel_enable high every other cycle on row 8'h81 -> same 8 pixels, outputs held on idle cycles, completion after 16 cycles.
REQ-037 Underrun: pixel_enable with no load -> pixel_color=0, pixel_active=0, one-cycle underrun=1 per enabled cycle.
REQ-038 Blink with SERIALIZER_BLINK_EN: row 8'hF0, fg=6, bg=0, blink=1, blink_phase=1 -> all 8 pixels 0; with blink_phase=0 -> 6,6,6,6,0,0,0,0.
REQ-039 Reset after 3 of 8 pixels with hold_full=1 -> outputs reset per REQ-028, load_ready=1, and the next pixel_enable raises underrun.
